// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a 2**DEPTH_LOG2-entry byte FIFO.
// Byte visible one cycle after its stop-bit sample; no backpressure: a push into a full FIFO drops the byte and sets overrun.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    input  logic                  uart_re,
    input  logic                  err_clr,
    output logic [7:0]            rd_data,
    output logic                  rx_valid,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  parity_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    logic                  r_sync1, r_sync2;
    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_timer, w_timer_nxt;
    logic [2:0]            r_bit_idx, w_bit_nxt;
    logic [7:0]            r_shift, w_shift_nxt;
    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overrun, r_frame_err;
    logic                  w_rx_s, w_push, w_frame_ev, w_par_ok;
    logic                  w_pop, w_full, w_push_acc, w_overrun_ev;

    assign w_rx_s = r_sync2;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad, w_par_bad_nxt, w_parity_ev, r_parity_err;
    assign w_par_ok   = ~r_par_bad;
    assign parity_err = r_parity_err;
`else
    assign w_par_ok   = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + TW'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_frame_ev  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_parity_ev   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: if (r_timer == HALF_LAST) begin
                w_timer_nxt = '0;
                w_bit_nxt   = 3'd0;
                w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (r_timer == BIT_LAST) begin
                w_timer_nxt = '0;
                w_shift_nxt = {w_rx_s, r_shift[7:1]};
                w_bit_nxt   = r_bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
`else
                if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: if (r_timer == BIT_LAST) begin
                w_timer_nxt   = '0;
                w_par_bad_nxt = ^{r_shift, w_rx_s};
                w_state_nxt   = S_STOP;
            end
`endif
            S_STOP: if (r_timer == BIT_LAST) begin
                w_timer_nxt = '0;
                if (w_rx_s) begin
                    // Back to IDLE mid-stop-bit: half a bit of resync margin for the next start edge.
                    w_state_nxt = S_IDLE;
                    w_push      = w_par_ok;
`ifdef UART_RX_PARITY_EN
                    w_parity_ev = ~w_par_ok;
`endif
                end else begin
                    w_frame_ev  = 1'b1;
                    w_state_nxt = S_BREAK;
                end
            end
            S_BREAK: begin
                w_timer_nxt = '0;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign w_pop        = uart_re && (r_count != '0);
    assign w_full       = (r_count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign w_push_acc   = w_push && (!w_full || w_pop);
    assign w_overrun_ev = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push_acc) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)      r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            if (w_push_acc && !w_pop)      r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            else if (!w_push_acc && w_pop) r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            r_overrun   <= w_overrun_ev | (r_overrun & ~err_clr);
            r_frame_err <= w_frame_ev   | (r_frame_err & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_ev | (r_parity_err & ~err_clr);
        end
    end
`endif

    assign rd_data   = (r_count != '0) ? r_mem[r_rd_ptr] : 8'h00;
    assign rx_valid  = (r_count != '0);
    assign rx_count  = r_count;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clocks per bit; parity cases only with UART_RX_PARITY_EN.
module tb_uart_rx_fifo;
    localparam int CPB = 8;
    localparam int DL2 = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         uart_rx = 1'b1;
    logic         uart_re = 1'b0;
    logic         err_clr = 1'b0;
    logic [7:0]   rd_data;
    logic         rx_valid;
    logic [DL2:0] rx_count;
    logic         overrun, frame_err, parity_err;
`ifdef UART_RX_PARITY_EN
    logic         par_flip = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        logic [4:0] exp_count;
        logic [7:0] exp_head;
        logic       exp_ferr;
    } vec_t;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_re(uart_re), .err_clr(err_clr),
        .rd_data(rd_data), .rx_valid(rx_valid), .rx_count(rx_count), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; leaves the line at the stop-bit level.
    task automatic frame(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
        uart_rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(CPB);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx = (^b) ^ par_flip;
        cyc(CPB);
`endif
        uart_rx = stop_bit;
        for (int i = 0; i < CPB; i++) begin
            if (pop_at_stop && i == 6) uart_re = 1'b1;
            if (pop_at_stop && i == 7) uart_re = 1'b0;
            cyc(1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        frame(b, 1'b1, 1'b0);
        uart_rx = 1'b1;
        cyc(4);
    endtask

    task automatic pop();
        uart_re = 1'b1;
        cyc(1);
        uart_re = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] exp_q[$];

        vecs[0] = '{8'hA5, 1'b1, 5'd1, 8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 5'd2, 8'hA5, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 5'd2, 8'hA5, 1'b1};
        vecs[3] = '{8'h12, 1'b1, 5'd3, 8'hA5, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 5'd4, 8'hA5, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 5'd5, 8'hA5, 1'b1};

        cyc(3);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_count", 32'(rx_count), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'h00);
        check("reset flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
        rst_n = 1'b1;
        cyc(3);

        send_byte(8'hA5);
        check("A5 rx_valid", 32'(rx_valid), 32'd1);
        check("A5 rd_data", 32'(rd_data), 32'hA5);
        check("A5 rx_count", 32'(rx_count), 32'd1);
        pop();
        check("A5 popped rx_valid", 32'(rx_valid), 32'd0);
        check("A5 popped rd_data", 32'(rd_data), 32'h00);
        pop();
        check("empty pop rx_count", 32'(rx_count), 32'd0);

        uart_rx = 1'b0;
        cyc(3);
        uart_rx = 1'b1;
        cyc(20);
        check("glitch rx_count", 32'(rx_count), 32'd0);
        check("glitch flags", {29'd0, overrun, frame_err, parity_err}, 32'd0);
        send_byte(8'h3C);
        check("after glitch rd_data", 32'(rd_data), 32'h3C);
        check("after glitch rx_count", 32'(rx_count), 32'd1);
        pop();

        frame(8'h55, 1'b0, 1'b0);
        cyc(10);
        check("break frame_err", 32'(frame_err), 32'd1);
        check("break rx_count", 32'(rx_count), 32'd0);
        pulse_clr();
        cyc(29);
        check("break single frame_err", 32'(frame_err), 32'd0);
        uart_rx = 1'b1;
        cyc(4);
        send_byte(8'h12);
        check("post-break rd_data", 32'(rd_data), 32'h12);
        check("post-break rx_count", 32'(rx_count), 32'd1);
        pop();

        for (int i = 0; i < 6; i++) begin
            frame(vecs[i].dat, vecs[i].stop, 1'b0);
            uart_rx = 1'b1;
            cyc(4);
            if (vecs[i].stop) exp_q.push_back(vecs[i].dat);
            check($sformatf("vec%0d rx_count", i), 32'(rx_count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d head", i), 32'(rd_data), 32'(vecs[i].exp_head));
            check($sformatf("vec%0d frame_err", i), 32'(frame_err), 32'(vecs[i].exp_ferr));
        end
        foreach (exp_q[i]) begin
            check($sformatf("drain%0d rd_data", i), 32'(rd_data), 32'(exp_q[i]));
            pop();
        end
        check("drain rx_valid", 32'(rx_valid), 32'd0);
        pulse_clr();
        check("clr frame_err", 32'(frame_err), 32'd0);

        for (int b = 0; b <= 16; b++) send_byte(8'(b));
        check("overrun rx_count", 32'(rx_count), 32'd16);
        check("overrun flag", 32'(overrun), 32'd1);
        check("overrun head", 32'(rd_data), 32'h00);
        for (int b = 0; b < 16; b++) begin
            check($sformatf("ovr pop%0d", b), 32'(rd_data), 32'(b));
            pop();
        end
        check("ovr drained rx_valid", 32'(rx_valid), 32'd0);
        pulse_clr();
        check("clr overrun", 32'(overrun), 32'd0);

        for (int b = 8'h20; b <= 8'h2F; b++) send_byte(8'(b));
        check("full rx_count", 32'(rx_count), 32'd16);
        frame(8'h30, 1'b1, 1'b1);
        uart_rx = 1'b1;
        cyc(4);
        check("push+pop rx_count", 32'(rx_count), 32'd16);
        check("push+pop overrun", 32'(overrun), 32'd0);
        check("push+pop head", 32'(rd_data), 32'h21);
        for (int b = 8'h21; b <= 8'h30; b++) begin
            check($sformatf("pp pop %0h", b), 32'(rd_data), 32'(b));
            pop();
        end

        uart_rx = 1'b0;
        cyc(CPB);
        uart_rx = 1'b1;
        cyc(3 * CPB);
        rst_n = 1'b0;
        cyc(2);
        check("mid-frame reset rx_count", 32'(rx_count), 32'd0);
        rst_n = 1'b1;
        cyc(10);
        send_byte(8'h81);
        check("post-reset rx_count", 32'(rx_count), 32'd1);
        check("post-reset rd_data", 32'(rd_data), 32'h81);
        pop();

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_byte(8'h07);
        par_flip = 1'b0;
        check("parity_err set", 32'(parity_err), 32'd1);
        check("parity rx_count", 32'(rx_count), 32'd0);
        check("parity frame_err", 32'(frame_err), 32'd0);
        pulse_clr();
        check("parity_err clr", 32'(parity_err), 32'd0);
`else
        check("parity_err tied", 32'(parity_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver for the 3-stage pipeline core. It sits between the board-level serial input pin and the CPU load path. It oversamples the asynchronous serial line, deframes 8N1 characters (optionally 8E1), and queues received bytes in a small FIFO. The writeback stage pops the FIFO through a one-cycle read strobe when it executes a word load from the UART receive address, so characters are not lost while software is busy.

## Interface
Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit, ≥ 4 (434 gives 50 MHz / 115200).
- DEPTH_LOG2, 4: log2 of FIFO depth (depth = 16).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  serial line, idle high, asynchronous to clk.
- uart_re  in  1  pop strobe, one cycle per byte.
- err_clr  in  1  clears the sticky error flags.
- rd_data  out  8  byte at FIFO head; 8'h00 when empty.
- rx_valid  out  1  FIFO not empty.
- rx_count  out  DEPTH_LOG2+1  number of bytes held, 0..depth.
- overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky flag: a stop bit was sampled low.
- parity_err  out  1  sticky flag: a parity mismatch was detected; tied 0 when parity is not compiled in.

Reset values: rd_data=0, rx_valid=0, rx_count=0, overrun=0, frame_err=0, parity_err=0. The FIFO is emptied and the FSM returns to IDLE. The two-flop synchronizer resets to 1.

## Operation
- uart_rx passes through a 2-flop synchronizer. Every later reference to the line means the synchronized value (rx_s).
- The FSM has states IDLE, START, DATA, PARITY (macro only), STOP and BREAK. A bit-timer counts cycles and a bit-index counter (0..7) tracks data bits.
- IDLE: when rx_s = 0, clear the timer and go to START.
- START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s.
  - If it is 1, the low pulse was a glitch; return to IDLE with no flag set.
  - If it is 0, go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample rx_s and shift it in LSB first. After bit 7, go to PARITY (macro) or STOP.
- PARITY: after CLKS_PER_BIT cycles, sample rx_s. Even parity is expected: the XOR of the data bits and the parity bit must be 0. Record the result.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - If it is 1 and parity is OK, push the byte and go to IDLE. Returning mid-stop-bit gives half a bit of resync margin.
  - If it is 1 and parity is bad, set parity_err, drop the byte, and go to IDLE.
  - If it is 0, set frame_err, drop the byte, and go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. A held-low line therefore raises exactly one frame_err.
- FIFO: circular buffer with DEPTH_LOG2-bit read and write pointers that wrap modulo depth. rx_count is tracked separately.
  - Push when full: byte dropped, overrun set, contents unchanged.
  - Pop when empty: ignored, no underflow, pointers unchanged.
  - Push and pop in the same cycle: both take effect and rx_count is unchanged. This includes the full case, where the pop frees the slot and the push is accepted with no overrun.
- Errors: all three flags are sticky until err_clr is asserted. If err_clr and a new error event occur in the same cycle, the flag ends up set.

## Timing
- Synchronizer latency: 2 cycles from a pin edge to rx_s.
- A push occurs in the cycle the stop bit is sampled. rx_valid, rx_count and rd_data update on the next rising edge.
- rd_data is combinational from the head entry. After a pop, it shows the next byte in the cycle after the uart_re cycle.
- Flags update one cycle after the causing event or after err_clr.
- Reset asserted mid-frame aborts the character and discards the partial byte. After release the FSM starts in IDLE; a line that is still low is treated as a new start bit.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state is included, frames are 8E1, and parity_err is live.
- UART_RX_PARITY_EN undefined: frames are 8N1, the PARITY state and its logic are absent, and parity_err is constant 0.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Send 0xA5 (8N1) → rx_valid=1, rd_data=8'hA5, rx_count=1. Pulse uart_re → next cycle rx_valid=0, rd_data=0.
- 3-cycle low glitch on an idle line → no push and no flags set; a following 0x3C is received correctly.
- Send 0x55 with the stop bit driven 0, then hold the line low for 40 cycles → frame_err=1 once, rx_count=0. Release the line and send 0x12 → received. Pulse err_clr → frame_err=0.
- Send 0x00..0x10 (17 bytes) without pops → rx_count=16, overrun=1, head=0x00. Pop all 16 → bytes 0x00..0x0F in order.
- With the FIFO full, pulse uart_re in the same cycle as a stop-bit push → rx_count stays 16, overrun stays 0.
- Macro defined, send 0x07 with parity bit 0 → parity_err=1, nothing pushed. Assert rst_n=0 during DATA, release, then send 0x81 → only 0x81 is queued.
